stream_mux_nto1: RTL and testbench

//  Parametrised N:1 data multiplexer with valid/ready handshake and a registered output stage.

---
 rtl/mux_pkg.sv | 22 ++
 rtl/stream_mux_nto1_if.sv | 32 +++
 rtl/stream_mux_nto1_comb.sv | 27 ++
 rtl/stream_mux_nto1.sv | 105 ++++++++++
 tb/tb_stream_mux_nto1.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the N:1 stream multiplexer.
// Holds the lock FSM encoding and a constant-foldable clog2.
package mux_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_st_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_mux_nto1_if.sv
// Handshake bundle between N producers, one consumer and the mux.
// master = surrounding system, slave = the mux itself.
interface stream_mux_nto1_if
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SEL_W = clog2(N);

  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_last;
  logic [N-1:0]     in_ready;
  logic [SEL_W-1:0] sel;
  logic             sel_err;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, in_last, sel, out_ready,
    input  in_ready, sel_err, out_data, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, sel, out_ready,
    output in_ready, sel_err, out_data, out_last, out_valid
  );

endinterface

// File: rtl/stream_mux_nto1_comb.sv
// Pure combinational N:1 select of {last, data} by active channel.
// Out-of-range selects yield zero.
module mux_nto1_comb
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [N*W-1:0]      in_data,
  input  logic [N-1:0]        in_last,
  input  logic [clog2(N)-1:0] act_sel,
  output logic [W-1:0]        y_data,
  output logic                y_last
);

  always_comb begin
    y_data = '0;
    y_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (act_sel == clog2(N)'(k)) begin
        y_data = in_data[k*W +: W];
        y_last = in_last[k];
      end
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// N:1 valid/ready stream mux with registered output stage.
// Define STREAM_MUX_LAST_LOCK_EN to hold the select for a whole packet.
module stream_mux_nto1
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic              clk,
  input logic              rst,
  stream_mux_nto1_if.slave bus
);

  localparam int SEL_W = clog2(N);

  logic [SEL_W-1:0] act_sel;
  logic [N-1:0]     rdy;
  logic [W-1:0]     m_data;
  logic             m_last;
  logic             load;
  logic             xfer;
  logic             err;
  logic [W-1:0]     q_data;
  logic             q_last;
  logic             q_valid;

`ifdef STREAM_MUX_LAST_LOCK_EN
  lock_st_t         state;
  lock_st_t         state_nx;
  logic [SEL_W-1:0] lock_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lock_sel <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && xfer && !m_last)
        lock_sel <= bus.sel;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (xfer && !m_last) state_nx = ST_LOCKED;
      ST_LOCKED: if (xfer && m_last)  state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    act_sel = bus.sel;
    if (state == ST_LOCKED)
      act_sel = lock_sel;
  end
`else
  always_comb begin
    act_sel = bus.sel;
  end
`endif

  mux_nto1_comb #(.N(N), .W(W)) u_sel (
    .in_data (bus.in_data),
    .in_last (bus.in_last),
    .act_sel (act_sel),
    .y_data  (m_data),
    .y_last  (m_last)
  );

  assign err  = (32'(act_sel) >= N);
  assign load = !q_valid || bus.out_ready;

  // Ready never looks at in_valid, so producers may wait on it safely.
  always_comb begin
    rdy = '0;
    if (load && !err && !rst)
      rdy = N'(1) << act_sel;
  end

  assign xfer = |(bus.in_valid & rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_last  <= 1'b0;
    end else if (load) begin
      if (xfer) begin
        q_valid <= 1'b1;
        q_data  <= m_data;
        q_last  <= m_last;
      end else begin
        q_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.sel_err   = err;
  assign bus.out_data  = q_data;
  assign bus.out_last  = q_last;
  assign bus.out_valid = q_valid;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed bench for stream_mux_nto1 (N=4 main, N=3 range).
// Lock expectations follow STREAM_MUX_LAST_LOCK_EN.
module tb_stream_mux_nto1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stream_mux_nto1_if #(.N(4), .W(8)) if4 ();
  stream_mux_nto1_if #(.N(3), .W(8)) if3 ();

  stream_mux_nto1 #(.N(4), .W(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  stream_mux_nto1 #(.N(3), .W(8)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input int k, input logic [7:0] d,
                      input logic l);
    if4.in_data[k*8 +: 8] = d;
    if4.in_last[k]        = l;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (if4.out_valid !== 1'b0 || if4.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_hold got v=%b rdy=%b exp v=0 rdy=0000",
               if4.out_valid, if4.in_ready);
    end
    step();
    rst = 1'b0;
    if4.sel = 2'd0;
    set4(0, 8'h5A, 1'b1);
    if4.in_valid = 4'b0001;
    step();
    checks++;
    if (if4.out_valid !== 1'b1 || if4.out_data !== 8'h5A) begin
      errors++;
      $display("FAIL rst_pre got v=%b d=%h exp v=1 d=5a",
               if4.out_valid, if4.out_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (if4.out_valid !== 1'b0 || if4.out_data !== 8'h00 ||
        if4.out_last !== 1'b0 || if4.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async got v=%b d=%h l=%b rdy=%b exp 0 00 0 0000",
               if4.out_valid, if4.out_data, if4.out_last,
               if4.in_ready);
    end
    if4.in_valid = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_select();
    if4.sel       = 2'd2;
    set4(2, 8'hA5, 1'b1);
    if4.in_valid  = 4'b0100;
    if4.out_ready = 1'b1;
    #1;
    checks++;
    if (if4.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL sel_rdy got %b exp 0100", if4.in_ready);
    end
    step();
    checks++;
    if (if4.out_valid !== 1'b1 || if4.out_data !== 8'hA5) begin
      errors++;
      $display("FAIL sel_data got v=%b d=%h exp v=1 d=a5",
               if4.out_valid, if4.out_data);
    end
    for (int i = 0; i < 16; i++) begin
      set4(2, 8'(8'h20 + i), 1'b1);
      step();
      checks++;
      if (if4.out_valid !== 1'b1 ||
          if4.out_data !== 8'(8'h20 + i)) begin
        errors++;
        $display("FAIL stream beat %0d got v=%b d=%h exp v=1 d=%h",
                 i, if4.out_valid, if4.out_data, 8'(8'h20 + i));
      end
    end
  endtask

  task automatic test_backpressure();
    if4.out_ready = 1'b0;
    set4(2, 8'hB0, 1'b1);
    #1;
    checks++;
    if (if4.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL bp_rdy got %b exp 0000", if4.in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (if4.out_valid !== 1'b1 || if4.out_data !== 8'h2F) begin
        errors++;
        $display("FAIL bp_hold %0d got v=%b d=%h exp v=1 d=2f",
                 i, if4.out_valid, if4.out_data);
      end
    end
    if4.out_ready = 1'b1;
    #1;
    checks++;
    if (if4.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release got %b exp 0100", if4.in_ready);
    end
    step();
    checks++;
    if (if4.out_valid !== 1'b1 || if4.out_data !== 8'hB0) begin
      errors++;
      $display("FAIL bp_next got v=%b d=%h exp v=1 d=b0",
               if4.out_valid, if4.out_data);
    end
    if4.in_valid = 4'b0000;
    step();
    checks++;
    if (if4.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got v=%b exp 0", if4.out_valid);
    end
  endtask

  task automatic test_range();
    if3.out_ready = 1'b1;
    if3.in_data   = {8'h77, 8'h66, 8'h55};
    if3.in_last   = 3'b111;
    if3.in_valid  = 3'b111;
    if3.sel       = 2'b11;
    if4.sel       = 2'b11;
    #1;
    checks++;
    if (if3.sel_err !== 1'b1 || if3.in_ready !== 3'b000) begin
      errors++;
      $display("FAIL range_err got e=%b rdy=%b exp e=1 rdy=000",
               if3.sel_err, if3.in_ready);
    end
    checks++;
    if (if4.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL range_n4 got e=%b exp 0", if4.sel_err);
    end
    step();
    step();
    checks++;
    if (if3.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL range_drain got v=%b exp 0", if3.out_valid);
    end
    if3.sel = 2'd2;
    #1;
    checks++;
    if (if3.sel_err !== 1'b0 || if3.in_ready !== 3'b100) begin
      errors++;
      $display("FAIL range_top got e=%b rdy=%b exp e=0 rdy=100",
               if3.sel_err, if3.in_ready);
    end
    step();
    checks++;
    if (if3.out_valid !== 1'b1 || if3.out_data !== 8'h77) begin
      errors++;
      $display("FAIL range_top_data got v=%b d=%h exp v=1 d=77",
               if3.out_valid, if3.out_data);
    end
    if3.in_valid = 3'b000;
    step();
  endtask

  task automatic test_lock();
    logic [3:0] exp_rdy;
    logic [7:0] exp_d;
    logic       exp_l;
`ifdef STREAM_MUX_LAST_LOCK_EN
    exp_rdy = 4'b0010;
`else
    exp_rdy = 4'b1000;
`endif
    if4.out_ready = 1'b1;
    if4.sel = 2'd1;
    set4(1, 8'h10, 1'b0);
    set4(3, 8'h33, 1'b1);
    if4.in_valid = 4'b1010;
    #1;
    checks++;
    if (if4.in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL lock_first_rdy got %b exp 0010", if4.in_ready);
    end
    step();
    checks++;
    if (if4.out_data !== 8'h10 || if4.out_last !== 1'b0) begin
      errors++;
      $display("FAIL lock_b1 got d=%h l=%b exp d=10 l=0",
               if4.out_data, if4.out_last);
    end
    if4.sel = 2'd3;
    set4(1, 8'h11, 1'b0);
    #1;
    checks++;
    if (if4.in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL lock_rdy got %b exp %b", if4.in_ready, exp_rdy);
    end
    step();
`ifdef STREAM_MUX_LAST_LOCK_EN
    exp_d = 8'h11;
    exp_l = 1'b0;
`else
    exp_d = 8'h33;
    exp_l = 1'b1;
`endif
    checks++;
    if (if4.out_data !== exp_d || if4.out_last !== exp_l) begin
      errors++;
      $display("FAIL lock_b2 got d=%h l=%b exp d=%h l=%b",
               if4.out_data, if4.out_last, exp_d, exp_l);
    end
    set4(1, 8'h12, 1'b1);
    step();
`ifdef STREAM_MUX_LAST_LOCK_EN
    exp_d = 8'h12;
`else
    exp_d = 8'h33;
`endif
    checks++;
    if (if4.out_data !== exp_d || if4.out_last !== 1'b1) begin
      errors++;
      $display("FAIL lock_b3 got d=%h l=%b exp d=%h l=1",
               if4.out_data, if4.out_last, exp_d);
    end
    step();
    checks++;
    if (if4.out_valid !== 1'b1 || if4.out_data !== 8'h33) begin
      errors++;
      $display("FAIL lock_ch3 got v=%b d=%h exp v=1 d=33",
               if4.out_valid, if4.out_data);
    end
    if4.in_valid = 4'b0000;
    step();
  endtask

  task automatic test_lock_reset();
    if4.sel = 2'd1;
    set4(1, 8'h40, 1'b0);
    if4.in_valid = 4'b0010;
    step();
    if4.in_valid = 4'b0000;
    rst = 1'b1;
    #1;
    checks++;
    if (if4.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lrst_async got v=%b exp 0", if4.out_valid);
    end
    step();
    rst = 1'b0;
    if4.sel = 2'd0;
    set4(0, 8'h50, 1'b1);
    if4.in_valid = 4'b0001;
    #1;
    checks++;
    if (if4.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL lrst_sel got %b exp 0001", if4.in_ready);
    end
    step();
    checks++;
    if (if4.out_valid !== 1'b1 || if4.out_data !== 8'h50) begin
      errors++;
      $display("FAIL lrst_data got v=%b d=%h exp v=1 d=50",
               if4.out_valid, if4.out_data);
    end
    if4.in_valid = 4'b0000;
    step();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    if4.in_data   = '0;
    if4.in_valid  = '0;
    if4.in_last   = '0;
    if4.sel       = '0;
    if4.out_ready = 1'b1;
    if3.in_data   = '0;
    if3.in_valid  = '0;
    if3.in_last   = '0;
    if3.sel       = '0;
    if3.out_ready = 1'b1;
    test_reset();
    test_select();
    test_backpressure();
    test_range();
    test_lock();
    test_lock_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
